// File: rtl/core_icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Line geometry is fixed at 64 bytes / 8 refill beats of 64 bits.
package core_icache_pkg;

  localparam int ICACHE_LINE_BYTES = 64;
  localparam int ICACHE_BEATS      = 8;

  typedef enum logic {
    ICACHE_IDLE,
    ICACHE_REFILL
  } icache_state_t;

  function automatic logic [63:0] icache_line_base(input logic [63:0] addr);
    return {addr[63:6], 6'h0};
  endfunction

endpackage

// File: rtl/core_icache_data_ram.sv
// Line data storage: LINES x 512 bits, 64-bit beat write port, combinational
// 32-bit halfword-aligned read that zero-fills the upper half at the last halfword.
module icache_data_ram
  import core_icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX   = $clog2(LINES)
) (
  input  logic             i_clk,
  input  logic             i_we_i,
  input  logic [IDX-1:0]   i_wr_idx_i,
  input  logic [2:0]       i_wr_beat_i,
  input  logic [63:0]      i_wr_data_i,
  input  logic [IDX-1:0]   i_rd_idx_i,
  input  logic [4:0]       i_rd_hw_i,
  output logic [31:0]      o_rd_data_o
);

  logic [ICACHE_LINE_BYTES*8-1:0] mem_q [LINES];
  logic [ICACHE_LINE_BYTES*8-1:0] rd_line;

  always_ff @(posedge i_clk) begin
    if (i_we_i) begin
      mem_q[i_wr_idx_i][{i_wr_beat_i, 6'd0} +: 64] <= i_wr_data_i;
    end
  end

  // The last halfword has no successor in this line; the fetch stage stitches it.
  always_comb begin
    rd_line     = mem_q[i_rd_idx_i];
    o_rd_data_o = 32'h0;
    if (i_rd_hw_i == 5'd31) begin
      o_rd_data_o = {16'h0, rd_line[511:496]};
    end else begin
      o_rd_data_o = rd_line[{i_rd_hw_i, 4'd0} +: 32];
    end
  end

endmodule

// File: rtl/core_icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, 8-beat line refill.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module core_icache
  import core_icache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_addr,
  output logic [31:0] o_data,
  output logic        o_data_ready,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  input  logic [63:0] i_mem_data,
  input  logic        i_mem_valid,
  output logic        o_busy,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 64 - OFF - IDX;

  icache_state_t     state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [2:0]        beat_q;
  logic [63:0]       mem_addr_q;

  logic [IDX-1:0]    rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              hit, launch, beat_we, last_beat;
  logic [31:0]       rd_data;
  logic              unused_addr_bit;

  assign rd_idx = i_addr[OFF+IDX-1:OFF];
  assign rd_tag = i_addr[63:OFF+IDX];
  assign wr_idx = mem_addr_q[OFF+IDX-1:OFF];
  assign wr_tag = mem_addr_q[63:OFF+IDX];
  assign unused_addr_bit = i_addr[0];

  assign hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && (state_q == ICACHE_IDLE);
  assign launch    = (state_q == ICACHE_IDLE) && !hit && !i_flush;
  assign beat_we   = (state_q == ICACHE_REFILL) && i_mem_valid;
  assign last_beat = beat_we && (beat_q == 3'd7);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ICACHE_IDLE:   if (launch)    state_d = ICACHE_REFILL;
      ICACHE_REFILL: if (last_beat) state_d = ICACHE_IDLE;
      default:                      state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ICACHE_IDLE;
      valid_q    <= '0;
      beat_q     <= 3'd0;
      mem_addr_q <= 64'h0;
    end else begin
      state_q <= state_d;
      if (launch) mem_addr_q <= {i_addr[63:OFF], {OFF{1'b0}}};
      if (beat_we) beat_q <= beat_q + 3'd1;
      // A flush on the final beat wins: the freshly filled line stays invalid.
      if (i_flush) begin
        valid_q <= '0;
      end else if (last_beat) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (last_beat) tag_q[wr_idx] <= wr_tag;
  end

  icache_data_ram #(
    .LINES (LINES),
    .IDX   (IDX)
  ) u_data_ram (
    .i_clk       (i_clk),
    .i_we_i      (beat_we),
    .i_wr_idx_i  (wr_idx),
    .i_wr_beat_i (beat_q),
    .i_wr_data_i (i_mem_data),
    .i_rd_idx_i  (rd_idx),
    .i_rd_hw_i   (i_addr[5:1]),
    .o_rd_data_o (rd_data)
  );

  assign o_data       = hit ? rd_data : 32'h0;
  assign o_data_ready = hit;
  assign o_mem_req    = (state_q == ICACHE_REFILL);
  assign o_busy       = (state_q == ICACHE_REFILL);
  assign o_mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [63:0] prev_addr_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_addr_q <= 64'h0;
      hit_cnt_q   <= 32'h0;
      miss_cnt_q  <= 32'h0;
    end else begin
      prev_addr_q <= i_addr;
      if (hit && (i_addr != prev_addr_q)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (launch) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`else
  assign o_hit_count  = 32'h0;
  assign o_miss_count = 32'h0;
`endif

endmodule
